// File: rtl/slide_switch_debounce.sv
// Per-bit synchronizer and debouncer for slide switches, with registered
// rise/fall pulses and a sticky "any switch changed" flag.
module slide_switch_debounce #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed,
  input  logic             changed_clr
);

  localparam int unsigned CNT_W =
    ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_upd;
  logic             w_any_pulse;

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_any_pulse = |(r_rise | r_fall);

  // Plain flop chain per bit; no logic between stages.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= sw_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // A bit is accepted once its differing level has been seen DEBOUNCE_CYCLES times in a row.
  always_comb begin
    w_upd = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_upd[i] = (w_sync[i] != r_out[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if ((w_sync[i] == r_out[i]) || w_upd[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out  <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_out  <= r_out ^ w_upd;
      r_rise <= w_upd & w_sync;
      r_fall <= w_upd & ~w_sync;
    end
  end

  // Set follows a pulse cycle and beats a coincident clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_changed <= 1'b0;
    end else if (w_any_pulse) begin
      r_changed <= 1'b1;
    end else if (changed_clr) begin
      r_changed <= 1'b0;
    end
  end

  assign sw_out  = r_out;
  assign sw_rise = r_rise;
  assign sw_fall = r_fall;
  assign changed = r_changed;

endmodule

// File: tb/tb_slide_switch_debounce.sv
// Directed bench for slide_switch_debounce with WIDTH=16, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8 (update lands on edge 10 after an input change).
module tb_slide_switch_debounce;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] sw_in;
  logic [15:0] sw_out;
  logic [15:0] sw_rise;
  logic [15:0] sw_fall;
  logic        changed;
  logic        changed_clr;

  int n_cmp = 0;
  int n_err = 0;

  slide_switch_debounce #(
    .WIDTH(16),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .sw_in(sw_in),
    .sw_out(sw_out),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .changed(changed),
    .changed_clr(changed_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] val);
    resetn = 1'b0;
    sw_in  = val;
    repeat (3) tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; sw_in = 16'hFFFF; changed_clr = 1'b0;
    repeat (3) tick();
    n_cmp++; if (sw_out !== 16'h0000) begin n_err++; $display("FAIL reset_sw_out: got %h want 0000", sw_out); end
    n_cmp++; if (sw_rise !== 16'h0000) begin n_err++; $display("FAIL reset_sw_rise: got %h want 0000", sw_rise); end
    n_cmp++; if (sw_fall !== 16'h0000) begin n_err++; $display("FAIL reset_sw_fall: got %h want 0000", sw_fall); end
    n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL reset_changed: got %b want 0", changed); end
    resetn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 9) begin
        n_cmp++; if (sw_out !== 16'h0000) begin n_err++; $display("FAIL reset_e9_out: got %h want 0000", sw_out); end
      end
      if (k == 10) begin
        n_cmp++; if (sw_out !== 16'hFFFF) begin n_err++; $display("FAIL reset_e10_out: got %h want FFFF", sw_out); end
        n_cmp++; if (sw_rise !== 16'hFFFF) begin n_err++; $display("FAIL reset_e10_rise: got %h want FFFF", sw_rise); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL reset_e10_changed: got %b want 0", changed); end
      end
      if (k == 11) begin
        n_cmp++; if (sw_rise !== 16'h0000) begin n_err++; $display("FAIL reset_e11_rise: got %h want 0000", sw_rise); end
        n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL reset_e11_changed: got %b want 1", changed); end
      end
    end
  endtask

  task automatic test_clean_edge();
    do_reset(16'h0000);
    sw_in = 16'h0008;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 9) begin
        n_cmp++; if (sw_out !== 16'h0000) begin n_err++; $display("FAIL clean_e9_out: got %h want 0000", sw_out); end
      end
      if (k == 10) begin
        n_cmp++; if (sw_out !== 16'h0008) begin n_err++; $display("FAIL clean_e10_out: got %h want 0008", sw_out); end
        n_cmp++; if (sw_rise !== 16'h0008) begin n_err++; $display("FAIL clean_e10_rise: got %h want 0008", sw_rise); end
        n_cmp++; if (sw_fall !== 16'h0000) begin n_err++; $display("FAIL clean_e10_fall: got %h want 0000", sw_fall); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL clean_e10_changed: got %b want 0", changed); end
      end
      if (k == 11) begin
        n_cmp++; if (sw_rise !== 16'h0000) begin n_err++; $display("FAIL clean_e11_rise: got %h want 0000", sw_rise); end
        n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL clean_e11_changed: got %b want 1", changed); end
      end
    end
  endtask

  task automatic test_bounce();
    int bad   = 0;
    int nrise = 0;
    do_reset(16'h0000);
    for (int b = 0; b < 3; b++) begin
      sw_in = 16'h0001;
      repeat (7) begin
        tick();
        if (sw_out !== 16'h0000 || sw_fall !== 16'h0000) bad++;
        if (sw_rise[0] === 1'b1) nrise++;
      end
      sw_in = 16'h0000;
      repeat (2) begin
        tick();
        if (sw_out !== 16'h0000 || sw_fall !== 16'h0000) bad++;
        if (sw_rise[0] === 1'b1) nrise++;
      end
    end
    sw_in = 16'h0001;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (sw_rise[0] === 1'b1) nrise++;
      if (k == 9) begin
        n_cmp++; if (sw_out !== 16'h0000) begin n_err++; $display("FAIL bounce_e9_out: got %h want 0000", sw_out); end
      end
      if (k == 10) begin
        n_cmp++; if (sw_out !== 16'h0001) begin n_err++; $display("FAIL bounce_e10_out: got %h want 0001", sw_out); end
        n_cmp++; if (sw_rise !== 16'h0001) begin n_err++; $display("FAIL bounce_e10_rise: got %h want 0001", sw_rise); end
      end
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bounce_stable: got %0d bad cycles want 0", bad); end
    n_cmp++; if (nrise !== 1) begin n_err++; $display("FAIL bounce_pulses: got %0d rise pulses want 1", nrise); end
  endtask

  task automatic test_independent();
    do_reset(16'h0000);
    sw_in = 16'h0020;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 10) begin
        n_cmp++; if (sw_out !== 16'h0020) begin n_err++; $display("FAIL indep_e10_out: got %h want 0020", sw_out); end
        n_cmp++; if (sw_rise !== 16'h0020) begin n_err++; $display("FAIL indep_e10_rise: got %h want 0020", sw_rise); end
      end
      if (k == 11) begin
        n_cmp++; if (sw_rise !== 16'h0000) begin n_err++; $display("FAIL indep_e11_rise: got %h want 0000", sw_rise); end
      end
      if (k == 12) begin
        n_cmp++; if (sw_out !== 16'h0020) begin n_err++; $display("FAIL indep_e12_out: got %h want 0020", sw_out); end
      end
      if (k == 13) begin
        n_cmp++; if (sw_out !== 16'h0220) begin n_err++; $display("FAIL indep_e13_out: got %h want 0220", sw_out); end
        n_cmp++; if (sw_rise !== 16'h0200) begin n_err++; $display("FAIL indep_e13_rise: got %h want 0200", sw_rise); end
      end
      if (k == 14) begin
        n_cmp++; if (sw_rise !== 16'h0000) begin n_err++; $display("FAIL indep_e14_rise: got %h want 0000", sw_rise); end
      end
      if (k == 3) sw_in = 16'h0220;
    end
  endtask

  task automatic test_flag_race();
    // changed is 1 here; an idle clear drops it on the next edge
    changed_clr = 1'b1;
    tick();
    changed_clr = 1'b0;
    n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL flag_idle_clr: got %b want 0", changed); end
    sw_in = 16'h0222;
    changed_clr = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 10) begin
        n_cmp++; if (sw_out !== 16'h0222) begin n_err++; $display("FAIL flag_e10_out: got %h want 0222", sw_out); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL flag_held_e10: got %b want 0", changed); end
      end
      if (k == 11) begin
        n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL flag_held_e11: got %b want 1", changed); end
      end
      if (k == 12) begin
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL flag_held_e12: got %b want 0", changed); end
      end
    end
    changed_clr = 1'b0;
    sw_in = 16'h0220;
    for (int k = 1; k <= 13; k++) begin
      tick();
      changed_clr = 1'b0;
      if (k == 10) begin
        n_cmp++; if (sw_fall !== 16'h0002) begin n_err++; $display("FAIL flag_e10_fall: got %h want 0002", sw_fall); end
        n_cmp++; if (sw_rise !== 16'h0000) begin n_err++; $display("FAIL flag_e10_rise: got %h want 0000", sw_rise); end
        changed_clr = 1'b1;
      end
      if (k == 11) begin
        n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL flag_race_e11: got %b want 1", changed); end
        n_cmp++; if (sw_fall !== 16'h0000) begin n_err++; $display("FAIL flag_e11_fall: got %h want 0000", sw_fall); end
      end
      if (k == 12) begin
        n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL flag_e12_hold: got %b want 1", changed); end
        changed_clr = 1'b1;
      end
      if (k == 13) begin
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL flag_e13_clr: got %b want 0", changed); end
      end
    end
  endtask

  task automatic test_mid_count_reset();
    sw_in = 16'h0224;
    repeat (5) tick();
    #3;
    resetn = 1'b0;
    #1;
    n_cmp++; if (sw_out !== 16'h0000) begin n_err++; $display("FAIL midrst_out: got %h want 0000", sw_out); end
    n_cmp++; if (sw_rise !== 16'h0000 || sw_fall !== 16'h0000) begin n_err++; $display("FAIL midrst_pulses: got %h/%h want 0000/0000", sw_rise, sw_fall); end
    n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL midrst_changed: got %b want 0", changed); end
    tick();
    tick();
    resetn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 9) begin
        n_cmp++; if (sw_out !== 16'h0000) begin n_err++; $display("FAIL midrst_e9_out: got %h want 0000", sw_out); end
      end
      if (k == 10) begin
        n_cmp++; if (sw_out !== 16'h0224) begin n_err++; $display("FAIL midrst_e10_out: got %h want 0224", sw_out); end
        n_cmp++; if (sw_rise !== 16'h0224) begin n_err++; $display("FAIL midrst_e10_rise: got %h want 0224", sw_rise); end
      end
      if (k == 11) begin
        n_cmp++; if (sw_rise !== 16'h0000) begin n_err++; $display("FAIL midrst_e11_rise: got %h want 0000", sw_rise); end
        n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL midrst_e11_changed: got %b want 1", changed); end
      end
    end
  endtask

  initial begin
    resetn      = 1'b0;
    sw_in       = 16'h0000;
    changed_clr = 1'b0;
    test_reset();
    test_clean_edge();
    test_bounce();
    test_independent();
    test_flag_race();
    test_mid_count_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slide_switch_debounce.md
Name: slide_switch_debounce

Overview:
Per-bit synchronizer and debouncer for the board slide switches. It sits directly upstream of the processing-system GPIO input (gpio_io_i). It converts raw asynchronous, bouncing switch levels into clean levels synchronous to the system clock. It also produces per-bit edge pulses and a sticky "any switch changed" flag that firmware can poll and clear.

Parameters:
- WIDTH, 16, number of switch bits.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; must be >= 2.
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a new level must persist before it is accepted (10 ms at 100 MHz); must be >= 2.

Ports:
- clk  input  1  system clock; all logic is in this single domain.
- resetn  input  1  asynchronous active-low reset.
- sw_in  input  WIDTH  raw switch pins, asynchronous to clk.
- sw_out  output  WIDTH  debounced stable levels; drives gpio_io_i.
- sw_rise  output  WIDTH  one-cycle pulse when the corresponding sw_out bit goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse when the corresponding sw_out bit goes 1->0.
- changed  output  1  sticky flag, set when any sw_out bit changes.
- changed_clr  input  1  synchronous clear for changed.

Behaviour:
- Reset is asynchronous and active-low.
  - Asserting resetn=0 immediately forces all synchronizer stages, all counters, sw_out, sw_rise, sw_fall and changed to 0.
  - Reset may assert mid-count; the count in progress is discarded.
  - Deassertion is assumed to be externally synchronized to clk.
- Synchronizer:
  - Each bit of sw_in passes through SYNC_STAGES flops.
  - The last stage is sync[i].
  - No logic sits between stages.
- Per-bit counter:
  - Width is $clog2(DEBOUNCE_CYCLES), with a minimum of 1.
  - Bits are fully independent; no counter is shared.
- At each rising edge of clk, per bit i:
  - If sync[i] == sw_out[i]: cnt[i] <= 0. Any glitch shorter than DEBOUNCE_CYCLES is rejected and the count restarts.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: sw_out[i] <= sync[i] and cnt[i] <= 0. On the same edge, sw_rise[i] or sw_fall[i] is registered high for exactly one cycle.
  - Else: cnt[i] <= cnt[i]+1.
- Latency: if sw_in changes before edge 1 and then holds, sw_out updates on edge SYNC_STAGES+DEBOUNCE_CYCLES. The rise/fall pulse is high in the cycle after that same edge.
- Edge pulses:
  - Registered, one cycle wide.
  - A default-low pulse output is never high for two consecutive cycles on the same bit.
  - sw_rise[i] and sw_fall[i] are never both high.
- changed flag:
  - Set on the edge after any sw_rise or sw_fall bit is asserted; equivalently, set when any bit updates.
  - Cleared on an edge where changed_clr=1 and no new update occurs.
  - If an update and changed_clr coincide, set wins and changed stays 1.
  - changed_clr held high continuously keeps changed low except on cycles where an update occurs.
- Counter wrap: the counter never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.
- Simultaneous events: any number of bits may update on the same edge. Each bit raises its own pulse, and changed sets once.

Test Plan:
All scenarios use WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=8 unless stated.
1. Reset: hold resetn=0 with sw_in=16'hFFFF -> sw_out=0, sw_rise=0, sw_fall=0, changed=0. Release reset; sw_out=16'hFFFF after edge 10. Check sw_rise=16'hFFFF for one cycle, and changed=1 from the next cycle.
2. Clean edge: from sw_out=0, set sw_in[3]=1 and hold -> sw_out[3] rises exactly at edge 10. Check sw_rise=16'h0008 for one cycle, sw_fall=0, and no other bits change.
3. Bounce rejection: toggle sw_in[0] with high pulses of 7 cycles and low gaps of 2 cycles, then hold high -> sw_out[0] does not change during the bouncing. It rises 10 edges after the final hold begins, and only one sw_rise pulse occurs.
4. Independent bits: set sw_in[5]=1 at t0 and sw_in[9]=1 at t0+3 -> sw_out[5] updates at edge 10 and sw_out[9] at edge 13. Check two separate single-cycle pulses.
5. Flag race: pulse changed_clr=1 on the same cycle an update occurs -> changed remains 1. Pulse changed_clr=1 on a later idle cycle -> changed=0 on the next edge.
6. Mid-count reset: drive sw_in[2]=1, assert resetn=0 after 5 cycles, then release -> all outputs are 0 immediately on assert. After release, the full 10-edge latency restarts from zero.
